// File: rtl/store_queue_fwd.sv
// Store queue: in-order allocation, AGU fill, one-at-a-time commit drain to the dcache,
// store-to-load forwarding and tail-restoring partial flush.
module store_queue_fwd #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int FWD_EN = 1,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    input  logic [TAG_W-1:0] enq_rob_tag,
    output logic             enq_ready,
    output logic [PTR_W-1:0] enq_idx,
    input  logic             wr_valid,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [2:0]       wr_funct3,
    input  logic [TAG_W-1:0] rob_head,
    input  logic             flush,
    input  logic [PTR_W-1:0] recover_tail,
    output logic             dmem_req,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_resp,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_rob_tag,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_rmask,
    input  logic [PTR_W-1:0] ld_sq_tail,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             fwd_stall,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty
);
    // Drain FSM
    //   state  | meaning
    //   S_IDLE | waiting for the head store to become ready and reach the ROB head
    //   S_REQ  | write request held on dmem_* until dmem_resp
    localparam int IDX_W = PTR_W - 1;
    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    logic             r_valid [DEPTH];
    logic             r_ready [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [29:0]      r_addr  [DEPTH];
    logic [3:0]       r_wmask [DEPTH];
    logic [31:0]      r_wdata [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_state;
    logic [29:0]      r_dmem_addr;
    logic [3:0]       r_dmem_wmask;
    logic [31:0]      r_dmem_wdata;
    logic             r_cdb_valid;
    logic [TAG_W-1:0] r_cdb_tag;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [1:0]       w_a;
    logic             w_enq;
    logic             w_wr;
    logic             w_commit;
    logic             w_pop;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wdata;
    logic [PTR_W-1:0] w_flush_n;
    logic [DEPTH-1:0] w_flush_clr;
    logic             w_unused;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_wr_idx   = wr_idx[IDX_W-1:0];
    assign w_a        = wr_addr[1:0];
    assign w_unused   = ^{ld_addr[1:0], wr_idx[IDX_W]};

    assign count     = r_tail - r_head;
    assign full      = (count == PTR_W'(DEPTH));
    assign empty     = (r_head == r_tail);
    assign enq_ready = !full;
    assign enq_idx   = r_tail;

    assign w_enq    = enq_valid && !full && !flush;
    assign w_wr     = wr_valid && r_valid[w_wr_idx];
    assign w_commit = r_valid[w_head_idx] && r_ready[w_head_idx] && (r_tag[w_head_idx] == rob_head);
    assign w_pop    = (r_state == S_REQ) && dmem_resp;

    always_comb begin
        w_wmask = 4'b0000;
        case (wr_funct3)
            3'b000:  w_wmask = 4'b0001 << w_a;
            3'b001:  w_wmask = 4'b0011 << w_a;
            3'b010:  w_wmask = 4'b1111;
            default: w_wmask = 4'b0000;
        endcase
    end
    assign w_wdata = wr_data << {w_a, 3'b000};

    // Entries in [recover_tail, old tail) are discarded; offsets are taken modulo DEPTH.
    assign w_flush_n = r_tail - recover_tail;
    always_comb begin
        logic [IDX_W-1:0] off;
        w_flush_clr = '0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = IDX_W'(i) - recover_tail[IDX_W-1:0];
            w_flush_clr[i] = ({1'b0, off} < w_flush_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_addr[i]  <= '0;
                r_wmask[i] <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enq && (w_tail_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_ready[i] <= 1'b0;
                    r_tag[i]   <= enq_rob_tag;
                end
                if (w_wr && (w_wr_idx == IDX_W'(i))) begin
                    r_ready[i] <= 1'b1;
                    r_addr[i]  <= wr_addr[31:2];
                    r_wmask[i] <= w_wmask;
                    r_wdata[i] <= w_wdata;
                end
                if ((w_pop && (w_head_idx == IDX_W'(i))) || (flush && w_flush_clr[i])) begin
                    r_valid[i] <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop) r_head <= r_head + PTR_W'(1);
            if (flush)      r_tail <= recover_tail;
            else if (w_enq) r_tail <= r_tail + PTR_W'(1);
        end
    end

    // dmem_* is latched on entry to S_REQ so it stays stable for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dmem_addr  <= '0;
            r_dmem_wmask <= '0;
            r_dmem_wdata <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_tag    <= '0;
        end else begin
            r_cdb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_commit) begin
                        r_state      <= S_REQ;
                        r_dmem_addr  <= r_addr[w_head_idx];
                        r_dmem_wmask <= r_wmask[w_head_idx];
                        r_dmem_wdata <= r_wdata[w_head_idx];
                    end
                end
                default: begin
                    if (dmem_resp) begin
                        r_state     <= S_IDLE;
                        r_cdb_valid <= 1'b1;
                        r_cdb_tag   <= r_tag[w_head_idx];
                    end
                end
            endcase
        end
    end

    assign dmem_req    = (r_state == S_REQ);
    assign dmem_addr   = {r_dmem_addr, 2'b00};
    assign dmem_wmask  = r_dmem_wmask;
    assign dmem_wdata  = r_dmem_wdata;
    assign cdb_valid   = r_cdb_valid;
    assign cdb_rob_tag = r_cdb_tag;

    // Walk oldest to youngest so the youngest relevant entry has the final say;
    // an unready entry younger than any match hides it and forces a stall.
    logic        w_unk;
    logic        w_match;
    logic        w_cover;
    logic [31:0] w_match_data;
    always_comb begin
        logic [PTR_W-1:0] older_n;
        logic [PTR_W-1:0] p;
        logic [IDX_W-1:0] idx;
        w_unk        = 1'b0;
        w_match      = 1'b0;
        w_cover      = 1'b0;
        w_match_data = '0;
        older_n      = ld_sq_tail - r_head;
        p            = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            p   = r_head + PTR_W'(k);
            idx = p[IDX_W-1:0];
            if ((PTR_W'(k) < older_n) && r_valid[idx]) begin
                if (!r_ready[idx]) begin
                    w_unk   = 1'b1;
                    w_match = 1'b0;
                end else if ((r_addr[idx] == ld_addr[31:2]) && ((r_wmask[idx] & ld_rmask) != 4'b0000)) begin
                    w_unk        = 1'b0;
                    w_match      = 1'b1;
                    w_cover      = ((r_wmask[idx] & ld_rmask) == ld_rmask);
                    w_match_data = r_wdata[idx];
                end
            end
        end
    end

    assign fwd_hit   = (FWD_EN != 0) && w_match && w_cover && !w_unk;
    assign fwd_stall = w_unk || (w_match && (!w_cover || (FWD_EN == 0)));
    assign fwd_data  = fwd_hit ? w_match_data : 32'h0;

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd (DEPTH=4); a second instance with forwarding
// disabled shares the stimulus so both forwarding policies are checked side by side.
module tb_store_queue_fwd;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             enq_valid;
    logic [4:0]       enq_rob_tag;
    logic             wr_valid;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [2:0]       wr_funct3;
    logic [4:0]       rob_head;
    logic             flush;
    logic [PTR_W-1:0] recover_tail;
    logic             dmem_resp;
    logic [31:0]      ld_addr;
    logic [3:0]       ld_rmask;
    logic [PTR_W-1:0] ld_sq_tail;

    logic             enq_ready, dmem_req, cdb_valid, fwd_hit, fwd_stall, full, empty;
    logic [PTR_W-1:0] enq_idx, count;
    logic [31:0]      dmem_addr, dmem_wdata, fwd_data;
    logic [3:0]       dmem_wmask;
    logic [4:0]       cdb_rob_tag;

    logic             n_enq_ready, n_dmem_req, n_cdb_valid, n_fwd_hit, n_fwd_stall, n_full, n_empty;
    logic [PTR_W-1:0] n_enq_idx, n_count;
    logic [31:0]      n_dmem_addr, n_dmem_wdata, n_fwd_data;
    logic [3:0]       n_dmem_wmask;
    logic [4:0]       n_cdb_rob_tag;

    store_queue_fwd #(.DEPTH(4), .TAG_W(5), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_rob_tag(enq_rob_tag), .enq_ready(enq_ready), .enq_idx(enq_idx),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_addr(wr_addr), .wr_data(wr_data), .wr_funct3(wr_funct3),
        .rob_head(rob_head), .flush(flush), .recover_tail(recover_tail),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
        .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_sq_tail(ld_sq_tail),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .count(count), .full(full), .empty(empty)
    );

    store_queue_fwd #(.DEPTH(4), .TAG_W(5), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_rob_tag(enq_rob_tag), .enq_ready(n_enq_ready), .enq_idx(n_enq_idx),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_addr(wr_addr), .wr_data(wr_data), .wr_funct3(wr_funct3),
        .rob_head(rob_head), .flush(flush), .recover_tail(recover_tail),
        .dmem_req(n_dmem_req), .dmem_addr(n_dmem_addr), .dmem_wmask(n_dmem_wmask), .dmem_wdata(n_dmem_wdata),
        .dmem_resp(dmem_resp), .cdb_valid(n_cdb_valid), .cdb_rob_tag(n_cdb_rob_tag),
        .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_sq_tail(ld_sq_tail),
        .fwd_hit(n_fwd_hit), .fwd_data(n_fwd_data), .fwd_stall(n_fwd_stall),
        .count(n_count), .full(n_full), .empty(n_empty)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] tag);
        enq_valid   = 1'b1;
        enq_rob_tag = tag;
        tick();
        enq_valid   = 1'b0;
    endtask

    task automatic agu(input logic [PTR_W-1:0] idx, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] f3);
        wr_valid  = 1'b1;
        wr_idx    = idx;
        wr_addr   = addr;
        wr_data   = data;
        wr_funct3 = f3;
        tick();
        wr_valid  = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [3:0] rmask, input logic [PTR_W-1:0] snap);
        ld_addr    = addr;
        ld_rmask   = rmask;
        ld_sq_tail = snap;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        enq_valid = 0; enq_rob_tag = 0; wr_valid = 0; wr_idx = 0; wr_addr = 0; wr_data = 0;
        wr_funct3 = 0; rob_head = 5'd31; flush = 0; recover_tail = 0; dmem_resp = 0;
        ld_addr = 0; ld_rmask = 0; ld_sq_tail = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_enq_idx", 32'(enq_idx), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_fwd", {30'd0, fwd_hit, fwd_stall}, 32'd0);
        rst = 1'b0;
        tick();

        // fill to capacity, fifth enqueue is dropped
        for (int i = 1; i <= 4; i++) enq(5'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_enq_ready", 32'(enq_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        enq(5'd5);
        check("full_drop_count", 32'(count), 32'd4);
        check("full_drop_idx", 32'(enq_idx), 32'd4);
        flush = 1'b1; recover_tail = 3'd0;
        tick();
        flush = 1'b0;
        check("flush_all_empty", 32'(empty), 32'd1);
        check("flush_all_idx", 32'(enq_idx), 32'd0);

        // sb commit and drain
        enq(5'd5);
        agu(3'd0, 32'h1003, 32'h0000_00AB, 3'b000);
        rob_head = 5'd5;
        #1;
        check("sb_req_pre", 32'(dmem_req), 32'd0);
        tick();
        check("sb_req", 32'(dmem_req), 32'd1);
        check("sb_addr", dmem_addr, 32'h0000_1000);
        check("sb_wmask", 32'(dmem_wmask), 32'h8);
        check("sb_wdata", dmem_wdata, 32'hAB00_0000);
        tick();
        check("sb_req_hold", 32'(dmem_req), 32'd1);
        check("sb_cdb_early", 32'(cdb_valid), 32'd0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        rob_head = 5'd31;
        check("sb_cdb_valid", 32'(cdb_valid), 32'd1);
        check("sb_cdb_tag", 32'(cdb_rob_tag), 32'd5);
        check("sb_req_drop", 32'(dmem_req), 32'd0);
        check("sb_empty", 32'(empty), 32'd1);
        tick();
        check("sb_cdb_pulse", 32'(cdb_valid), 32'd0);

        // sw forwarding (head=1, tail=1)
        check("sw_enq_idx", 32'(enq_idx), 32'd1);
        enq(5'd6);
        agu(3'd1, 32'h2000, 32'hDEAD_BEEF, 3'b010);
        load(32'h2000, 4'b0011, 3'd2);
        check("sw_fwd_hit", 32'(fwd_hit), 32'd1);
        check("sw_fwd_data", fwd_data, 32'hDEAD_BEEF);
        check("sw_fwd_stall", 32'(fwd_stall), 32'd0);
        check("sw_nf_stall", 32'(n_fwd_stall), 32'd1);
        check("sw_nf_hit", 32'(n_fwd_hit), 32'd0);
        load(32'h2000, 4'b0011, 3'd1);
        check("sw_not_older", {30'd0, fwd_hit, fwd_stall}, 32'd0);
        load(32'h2004, 4'b1111, 3'd2);
        check("sw_other_word", {30'd0, fwd_hit, fwd_stall}, 32'd0);

        // sh partial coverage, then an unready younger store
        enq(5'd7);
        agu(3'd2, 32'h3000, 32'h0000_1234, 3'b001);
        load(32'h3000, 4'b1111, 3'd3);
        check("sh_partial_stall", {30'd0, fwd_hit, fwd_stall}, 32'd1);
        load(32'h3000, 4'b0001, 3'd3);
        check("sh_cover_hit", 32'(fwd_hit), 32'd1);
        check("sh_cover_data", fwd_data, 32'h0000_1234);
        check("sh_nf_stall", {30'd0, n_fwd_hit, n_fwd_stall}, 32'd1);
        enq(5'd8);
        load(32'h2000, 4'b1111, 3'd4);
        check("unk_addr_stall", {30'd0, fwd_hit, fwd_stall}, 32'd1);
        load(32'h2000, 4'b1111, 3'd3);
        check("unk_out_of_range", 32'(fwd_hit), 32'd1);

        // head in REQ with 3 younger entries; flush coincides with dmem_resp
        rob_head = 5'd6;
        enq(5'd9);
        check("fl_count", 32'(count), 32'd4);
        check("fl_req", 32'(dmem_req), 32'd1);
        check("fl_addr", dmem_addr, 32'h0000_2000);
        flush = 1'b1; recover_tail = 3'd2; dmem_resp = 1'b1;
        tick();
        flush = 1'b0; dmem_resp = 1'b0; rob_head = 5'd31;
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_count_zero", 32'(count), 32'd0);
        check("fl_enq_idx", 32'(enq_idx), 32'd2);
        check("fl_cdb_tag", {26'd0, cdb_valid, cdb_rob_tag}, {26'd0, 1'b1, 5'd6});
        check("fl_req_drop", 32'(dmem_req), 32'd0);
        load(32'h3000, 4'b0001, 3'd5);
        check("fl_cleared_fwd", {30'd0, fwd_hit, fwd_stall}, 32'd0);

        // pointer wrap: 11 enqueue/commit rounds starting at index 2
        for (int n = 0; n < 11; n++) begin
            check("wr_enq_idx", 32'(enq_idx), 32'((2 + n) % 8));
            enq(5'(10 + n));
            agu(3'((2 + n) % 8), 32'h4000 + 32'(4 * n), 32'(n), 3'b010);
            rob_head = 5'(10 + n);
            tick();
            check("wr_addr", dmem_addr, 32'h4000 + 32'(4 * n));
            dmem_resp = 1'b1;
            tick();
            dmem_resp = 1'b0;
            check("wr_cdb_tag", 32'(cdb_rob_tag), 32'(10 + n));
            check("wr_empty", 32'(empty), 32'd1);
        end
        rob_head = 5'd31;
        for (int i = 0; i < 4; i++) enq(5'(21 + i));
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_count", 32'(count), 32'd4);
        check("wrap_enq_idx", 32'(enq_idx), 32'd1);
        check("wrap_empty", 32'(empty), 32'd0);
        flush = 1'b1; recover_tail = 3'd5;
        tick();
        flush = 1'b0;
        check("wrap_flush_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/store_queue_fwd.md
# store_queue_fwd

Parametrised store queue for the out-of-order memory unit. Allocates entries in program order at dispatch, accepts address/data from the store AGU, and writes committed stores to the data cache one at a time when each store reaches the ROB head. It adds three things: store-to-load forwarding for younger loads, pointer-based partial flush on branch recovery, and configurable depth and tag widths. It sits between dispatch/AGU and the dcache arbiter, alongside the load queue.

## Interface
- DEPTH, 8, entry count; power of two, ≥2
- TAG_W, 5, ROB tag width
- FWD_EN, 1, 1 = forwarding enabled; 0 = any older overlap stalls the load
- PTR_W (derived), $clog2(DEPTH)+1, pointer width including the wrap bit
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- enq_valid  in  1  allocate an entry at tail
- enq_rob_tag  in  TAG_W  ROB tag of the allocating store
- enq_ready  out  1  equals !full
- enq_idx  out  PTR_W  current tail; dispatch stores it with the store and with every younger load
- wr_valid  in  1  AGU result for one entry
- wr_idx  in  PTR_W  target entry; only the low bits index the array
- wr_addr, wr_data  in  32 each  byte address, raw store data
- wr_funct3  in  3  sb/sh/sw
- rob_head  in  TAG_W  tag at the ROB head
- flush  in  1  branch recovery pulse
- recover_tail  in  PTR_W  tail snapshot to restore
- dmem_req  out  1  write request
- dmem_addr  out  32  word-aligned address
- dmem_wmask  out  4  byte write mask
- dmem_wdata  out  32  lane-aligned write data
- dmem_resp  in  1  write-complete pulse
- cdb_valid  out  1  completion pulse
- cdb_rob_tag  out  TAG_W  ROB tag of the completed store
- ld_addr  in  32  word-aligned load address
- ld_rmask  in  4  load byte mask
- ld_sq_tail  in  PTR_W  the load's enq_idx snapshot
- fwd_hit  out  1  forwarding succeeded
- fwd_data  out  32  forwarded word, lane-aligned
- fwd_stall  out  1  load must wait
- count  out  PTR_W  number of occupied entries
- full, empty  out  1 each  queue state

## Operation
- Each entry holds: valid, ready, rob_tag, addr[31:2], wmask, wdata.
- Queue state: head and tail pointers of PTR_W bits.
  - count = tail − head, modulo 2^PTR_W.
  - full when count == DEPTH; empty when head == tail.
- Enqueue (enq_valid && !full && !flush):
  - entry[tail] gets valid=1, ready=0, rob_tag.
  - tail increments.
  - enq_valid while full is ignored.
- AGU write (wr_valid && entry[wr_idx].valid):
  - sets ready=1 and stores addr[31:2].
  - wmask: sb 0001<<a, sh 0011<<a, sw 1111, other 0000, where a = wr_addr[1:0].
  - wdata = wr_data << 8·a.
  - A write to an invalid entry is dropped. Upstream guarantees natural alignment.
- Drain FSM, two states:
  - IDLE→REQ when head entry valid && ready && rob_tag == rob_head. dmem_* is driven from entry[head].
  - In REQ, dmem_req holds high and dmem_* stays stable until dmem_resp.
  - On dmem_resp: entry[head] is cleared, head increments, state returns to IDLE.
  - dmem_resp in IDLE is ignored.
- Flush:
  - tail ← recover_tail.
  - Every entry in [recover_tail, old tail) is cleared.
  - head, the FSM and any in-flight request are untouched; the head store is committed and never flushed.
  - recover_tail lies in [head, tail]. If flush coincides with dmem_resp, the pop still happens.
  - An enqueue in the flush cycle is dropped.
- Forwarding (combinational). Older entries are those in [head, ld_sq_tail). Search from youngest to oldest:
  - an older entry with ready=0: fwd_stall=1.
  - otherwise the youngest ready entry with equal word address and (wmask & ld_rmask) ≠ 0 is the match:
    - if wmask covers ld_rmask: fwd_hit=1 and fwd_data = wdata;
    - else fwd_stall=1.
  - no match: both 0.
  - FWD_EN=0: any match forces fwd_stall=1, and fwd_hit is always 0.
  - fwd_hit and fwd_stall are never both 1.

## Timing
- Reset (async):
  - head=tail=0, all entries invalid, FSM=IDLE.
  - dmem_req=0, dmem_addr/wmask/wdata=0.
  - cdb_valid=0, cdb_rob_tag=0.
  - fwd_hit=fwd_stall=0, fwd_data=0.
  - count=0, empty=1, full=0, enq_ready=1, enq_idx=0.
- Reset in REQ aborts the request; dmem_req drops immediately.
- Commit detection to dmem_req: 1 cycle, since the FSM is registered. The minimum store occupancy from ready-at-head to pop is 2 cycles.
- cdb_valid is a registered one-cycle pulse in the cycle after dmem_resp and carries the popped tag.
- count, full and empty reflect registered pointers. A pop does not free space for an enqueue in the same cycle.
- enq_idx reflects the current tail. A same-cycle AGU write to a just-enqueued entry is dropped.
- Wrap: pointers roll over at 2^PTR_W, and the wrap bit distinguishes full from empty.

## Test plan
- DEPTH=4. Enqueue 4, then attempt a fifth → full=1, enq_ready=0, count=4, and the fifth is dropped.
- sb at 0x1003, data 0xAB, tag at rob_head → dmem_req one cycle later, addr 0x1000, wmask 1000, wdata 0xAB000000. Resp → cdb_valid next cycle with that tag.
- sw 0x2000, 0xDEADBEEF ready; load 0x2000, rmask 0011 with later snapshot → fwd_hit=1, fwd_data 0xDEADBEEF. Same load with FWD_EN=0 → fwd_stall=1.
- sh 0x3000 ready; load 0x3000, rmask 1111 → fwd_stall=1. An older store with unknown address → fwd_stall=1.
- Head store in REQ with 3 younger entries; flush with recover_tail=head+1, asserted in the same cycle as dmem_resp → pop completes and tail=head=old head+1 (empty=1).
- Drive 2·DEPTH+3 enqueue/commit cycles so the pointers wrap → order preserved, and full/empty stay correct across the wrap.
